// File: rtl/led_effect_sched.sv
// Round-robin scheduler that time-shares the 8-LED bank between four requesters,
// playing the winner's off/on/blink/breath effect for a fixed window.
module led_effect_sched #(
    parameter int CLK_PER_US = 50,
    parameter int US_PER_MS  = 1000,
    parameter int EFFECT_MS  = 2000,
    parameter int BLINK_MS   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [7:0] eff_sel,
    output logic [3:0] grant,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [7:0] led
);
    localparam int US_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int SL_W = (US_PER_MS  > 1) ? $clog2(US_PER_MS)  : 1;
    localparam int MS_W = (EFFECT_MS  > 1) ? $clog2(EFFECT_MS)  : 1;
    localparam int BL_W = (BLINK_MS   > 1) ? $clog2(BLINK_MS)   : 1;

    localparam logic [US_W-1:0] US_LAST = US_W'(CLK_PER_US - 1);
    localparam logic [SL_W-1:0] SL_LAST = SL_W'(US_PER_MS - 1);
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(EFFECT_MS - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_MS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_n;
    logic [1:0]      ptr, ptr_n;
    logic [1:0]      gidx, gidx_n;
    logic [1:0]      eff, eff_n;
    logic [US_W-1:0] us_cnt, us_cnt_n;
    logic [SL_W-1:0] slot_cnt, slot_cnt_n;
    logic [MS_W-1:0] ms_cnt, ms_cnt_n;
    logic [BL_W-1:0] blink_cnt, blink_cnt_n;
    logic            phase, phase_n;
    logic [SL_W-1:0] duty, duty_n;
    logic            dir_down, dir_down_n;
    logic [3:0]      grant_n;
    logic            busy_n, done_n, aborted_n;
    logic [7:0]      led_n;

    logic            tick_us, tick_ms;
    logic            found;
    logic [1:0]      win, idx;
    logic [7:0]      pattern;

    // Rotating-priority search starting at ptr.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        case (eff)
            2'b00:   pattern = '0;
            2'b01:   pattern = '1;
            2'b10:   pattern = {8{phase}};
            default: pattern = {8{slot_cnt < duty}};
        endcase
    end

    assign tick_us = (us_cnt == US_LAST);
    assign tick_ms = tick_us && (slot_cnt == SL_LAST);

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        gidx_n      = gidx;
        eff_n       = eff;
        us_cnt_n    = us_cnt;
        slot_cnt_n  = slot_cnt;
        ms_cnt_n    = ms_cnt;
        blink_cnt_n = blink_cnt;
        phase_n     = phase;
        duty_n      = duty;
        dir_down_n  = dir_down;
        grant_n     = grant;
        busy_n      = busy;
        done_n      = done;
        aborted_n   = aborted;
        led_n       = led;

        case (state)
            IDLE: begin
                led_n = '0;
                if (found) begin
                    state_n     = RUN;
                    grant_n     = 4'b0001 << win;
                    busy_n      = 1'b1;
                    gidx_n      = win;
                    eff_n       = eff_sel[2*win +: 2];
                    ptr_n       = win + 2'd1;
                    us_cnt_n    = '0;
                    slot_cnt_n  = '0;
                    ms_cnt_n    = '0;
                    blink_cnt_n = '0;
                    phase_n     = 1'b1;
                    duty_n      = '0;
                    dir_down_n  = 1'b0;
                end
            end

            RUN: begin
                led_n    = pattern;
                us_cnt_n = tick_us ? '0 : us_cnt + 1'b1;
                if (tick_us)
                    slot_cnt_n = (slot_cnt == SL_LAST) ? '0 : slot_cnt + 1'b1;
                if (tick_ms) begin
                    ms_cnt_n = (ms_cnt == MS_LAST) ? '0 : ms_cnt + 1'b1;
                    if (blink_cnt == BL_LAST) begin
                        blink_cnt_n = '0;
                        phase_n     = ~phase;
                    end else begin
                        blink_cnt_n = blink_cnt + 1'b1;
                    end
                    // Triangle: reversal happens in the same tick as the step away from the peak/floor.
                    if (!dir_down) begin
                        if (duty < SL_LAST) begin
                            duty_n = duty + 1'b1;
                        end else begin
                            dir_down_n = 1'b1;
                            duty_n     = (duty != '0) ? duty - 1'b1 : duty;
                        end
                    end else begin
                        if (duty != '0) begin
                            duty_n = duty - 1'b1;
                        end else begin
                            dir_down_n = 1'b0;
                            duty_n     = (duty < SL_LAST) ? duty + 1'b1 : duty;
                        end
                    end
                end
                if (!req[gidx]) begin
                    state_n   = DONE;
                    done_n    = 1'b1;
                    aborted_n = 1'b1;
                end else if (tick_ms && ms_cnt == MS_LAST) begin
                    state_n   = DONE;
                    done_n    = 1'b1;
                    aborted_n = 1'b0;
                end
            end

            default: begin
                state_n   = IDLE;
                grant_n   = '0;
                busy_n    = 1'b0;
                done_n    = 1'b0;
                aborted_n = 1'b0;
                led_n     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gidx      <= '0;
            eff       <= '0;
            us_cnt    <= '0;
            slot_cnt  <= '0;
            ms_cnt    <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            duty      <= '0;
            dir_down  <= 1'b0;
            grant     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            led       <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            gidx      <= gidx_n;
            eff       <= eff_n;
            us_cnt    <= us_cnt_n;
            slot_cnt  <= slot_cnt_n;
            ms_cnt    <= ms_cnt_n;
            blink_cnt <= blink_cnt_n;
            phase     <= phase_n;
            duty      <= duty_n;
            dir_down  <= dir_down_n;
            grant     <= grant_n;
            busy      <= busy_n;
            done      <= done_n;
            aborted   <= aborted_n;
            led       <= led_n;
        end
    end
endmodule

// File: tb/tb_led_effect_sched.sv
// Self-checking bench for led_effect_sched: a cycle-level behavioural model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_led_effect_sched;
    localparam int CPU     = 2;
    localparam int UPM     = 4;
    localparam int EMS     = 6;
    localparam int BMS     = 2;
    localparam int MS_CYC  = CPU * UPM;
    localparam int RUN_LEN = EMS * MS_CYC;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = '0;
    logic [7:0] eff_sel = '0;
    logic [3:0] grant;
    logic       busy, done, aborted;
    logic [7:0] led;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    int br_exp [6] = '{0, 2, 4, 6, 4, 2};
    int bl_exp [3] = '{16, 0, 16};

    led_effect_sched #(
        .CLK_PER_US(CPU),
        .US_PER_MS (UPM),
        .EFFECT_MS (EMS),
        .BLINK_MS  (BMS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .eff_sel(eff_sel),
        .grant  (grant),
        .busy   (busy),
        .done   (done),
        .aborted(aborted),
        .led    (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++)
            if (r[(p + i) % 4]) return (p + i) % 4;
        return p;
    endfunction

    function automatic int duty_of(input int ms);
        int per, r;
        per = 2 * (UPM - 1);
        r   = ms % per;
        return (r <= UPM - 1) ? r : per - r;
    endfunction

    // LED value owed for run-cycle k of an effect (appears one cycle later).
    function automatic logic [7:0] pattern_at(input logic [1:0] e, input int k);
        int ms, slot;
        ms   = k / MS_CYC;
        slot = (k % MS_CYC) / CPU;
        case (e)
            2'b00:   return 8'h00;
            2'b01:   return 8'hFF;
            2'b10:   return ((ms / BMS) % 2 == 0) ? 8'hFF : 8'h00;
            default: return (slot < duty_of(ms)) ? 8'hFF : 8'h00;
        endcase
    endfunction

    int         m_state, m_k, m_win, m_ptr, m_pick;
    logic [1:0] m_eff;
    logic [3:0] m_grant;
    logic       m_busy, m_done, m_aborted;
    logic [7:0] m_led;

    assign m_pick = pick(req, m_ptr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 0; m_k <= 0; m_win <= 0; m_ptr <= 0; m_eff <= '0;
            m_grant <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_aborted <= 1'b0; m_led <= '0;
        end else begin
            case (m_state)
                0: begin
                    m_led <= '0;
                    if (req != 4'b0) begin
                        m_win   <= m_pick;
                        m_grant <= 4'(1 << m_pick);
                        m_busy  <= 1'b1;
                        m_eff   <= eff_sel[2*m_pick +: 2];
                        m_ptr   <= (m_pick + 1) % 4;
                        m_k     <= 0;
                        m_state <= 1;
                    end
                end
                1: begin
                    m_led <= pattern_at(m_eff, m_k);
                    m_k   <= m_k + 1;
                    if (!req[m_win]) begin
                        m_state <= 2; m_done <= 1'b1; m_aborted <= 1'b1;
                    end else if (m_k == RUN_LEN - 1) begin
                        m_state <= 2; m_done <= 1'b1; m_aborted <= 1'b0;
                    end
                end
                default: begin
                    m_state <= 0; m_grant <= '0; m_busy <= 1'b0;
                    m_done <= 1'b0; m_aborted <= 1'b0; m_led <= '0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("model_grant",   grant,   m_grant);
            chk("model_busy",    busy,    m_busy);
            chk("model_done",    done,    m_done);
            chk("model_aborted", aborted, m_aborted);
            chk("model_led",     led,     m_led);
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        chk("wait_done", done, 1'b1);
    endtask

    initial begin
        int cnt;
        #2 rst = 1'b1;
        #20;
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("reset_grant", grant, 4'b0000);
        chk("reset_busy",  busy,  1'b0);
        chk("reset_led",   led,   8'h00);
        chk("reset_done",  done,  1'b0);

        // Round robin: 0101 held -> 0001 then 0100; later 0001 wins again with ptr=3.
        eff_sel = 8'b0101_0101;
        req     = 4'b0101;
        step(1);  chk("rr_first",  grant, 4'b0001);
        step(48); chk("rr_done0",  done,  1'b1);
        step(2);  chk("rr_second", grant, 4'b0100);
        step(48); chk("rr_done2",  done,  1'b1);
        req = 4'b0000;
        step(2);
        req = 4'b0001;
        step(1);  chk("rr_wrap",   grant, 4'b0001);
        step(48); chk("rr_done_w", done,  1'b1);
        req = 4'b0000;
        step(2);

        // Effect "on": exact grant/led/done timing.
        eff_sel = 8'b0000_0001;
        req     = 4'b0001;
        step(1);  chk("on_grant", grant, 4'b0001); chk("on_busy", busy, 1'b1);
        step(1);  chk("on_led",   led,   8'hFF);
        step(47); chk("on_done",  done,  1'b1);    chk("on_abort0", aborted, 1'b0);
        chk("on_grant_held", grant, 4'b0001);
        req = 4'b0000;
        step(1);  chk("on_grant_off", grant, 4'b0000); chk("on_led_off", led, 8'h00);
        step(1);

        // Blink on requester 1; eff_sel change mid-run must be ignored.
        eff_sel = 8'b0000_1000;
        req     = 4'b0010;
        step(1);
        for (int w = 0; w < 3; w++) begin
            cnt = 0;
            for (int c = 0; c < 16; c++) begin
                step(1);
                if (led == 8'hFF) cnt++;
            end
            chk("blink_window", cnt, bl_exp[w]);
            eff_sel = 8'h00;
        end
        chk("blink_done", done, 1'b1);
        req = 4'b0000;
        step(2);

        // Breath on requester 3: lit cycles per ms 0,2,4,6,4,2.
        eff_sel = 8'b1100_0000;
        req     = 4'b1000;
        step(1);
        for (int m = 0; m < 6; m++) begin
            cnt = 0;
            for (int c = 0; c < MS_CYC; c++) begin
                step(1);
                if (led == 8'hFF) cnt++;
            end
            chk("breath_ms", cnt, br_exp[m]);
        end
        chk("breath_done", done, 1'b1);
        req = 4'b0000;
        step(2);

        // Abort on requester 2, 10 cycles into RUN.
        eff_sel = 8'b0001_0000;
        req     = 4'b0100;
        step(1);  chk("ab_grant", grant, 4'b0100);
        step(9);
        req = 4'b0000;
        step(1);  chk("ab_done", done, 1'b1); chk("ab_aborted", aborted, 1'b1);
        chk("ab_grant_held", grant, 4'b0100);
        step(1);  chk("ab_led_off", led, 8'h00); chk("ab_grant_off", grant, 4'b0000);
        chk("ab_done_off", done, 1'b0);
        step(1);

        // Reset mid-run: outputs clear at once, no done, ptr back to 0.
        eff_sel = 8'b0000_0100;
        req     = 4'b0010;
        step(6);
        rst = 1'b1;
        #1;
        chk("rst_grant", grant, 4'b0000);
        chk("rst_busy",  busy,  1'b0);
        chk("rst_led",   led,   8'h00);
        chk("rst_done",  done,  1'b0);
        req = 4'b0000;
        step(2);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step(1);
            chk("rst_no_done", done, 1'b0);
        end
        eff_sel = 8'b0000_1000;
        req     = 4'b0110;
        step(1);  chk("rst_fresh_grant", grant, 4'b0010);
        wait_done(RUN_LEN + 4);
        req = 4'b0000;
        step(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
